// File: rtl/decode_queue.sv
// decode_queue: decoded-instruction FIFO between the fetch and decode stages.
// Each raw MIPS word is decoded as it is enqueued. The decoded fields are stored
// next to the instruction word and its PC in a DEPTH-entry circular buffer. The
// oldest entry is presented to the decode stage. All outputs are zero when the
// buffer is empty.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_ir,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_ir,
    output logic [31:0]      out_pc,
    output logic [5:0]       out_type,
    output logic [4:0]       out_a1,
    output logic [4:0]       out_a2,
    output logic [4:0]       out_a3,
    output logic             out_rs_use,
    output logic             out_rt_use,
    output logic             out_ri,
    output logic [PTR_W:0]   count
);

    // Instruction class codes. This numbering is shared with the rest of the pipeline.
    typedef enum logic [5:0] {
        T_NOP   = 6'd0,  T_ADD   = 6'd1,  T_SUB   = 6'd2,  T_AND   = 6'd3,
        T_OR    = 6'd4,  T_SLT   = 6'd5,  T_SLTU  = 6'd6,  T_LUI   = 6'd7,
        T_ADDI  = 6'd8,  T_ANDI  = 6'd9,  T_ORI   = 6'd10, T_LB    = 6'd11,
        T_LH    = 6'd12, T_LW    = 6'd13, T_SB    = 6'd14, T_SH    = 6'd15,
        T_SW    = 6'd16, T_MULT  = 6'd17, T_MULTU = 6'd18, T_DIV   = 6'd19,
        T_DIVU  = 6'd20, T_MFHI  = 6'd21, T_MFLO  = 6'd22, T_MTHI  = 6'd23,
        T_MTLO  = 6'd24, T_BEQ   = 6'd25, T_BNE   = 6'd26, T_JAL   = 6'd27,
        T_JR    = 6'd28, T_MFC0  = 6'd29, T_MTC0  = 6'd30, T_ERET  = 6'd31,
        T_SYSCALL = 6'd32
    } itype_e;

    // Where the destination register number comes from.
    typedef enum logic [1:0] {
        A3_ZERO,
        A3_RT,
        A3_RD,
        A3_RA
    } a3_sel_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        itype_e      itype;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic        rs_use;
        logic        rt_use;
        logic        ri;
    } entry_t;

    typedef logic [PTR_W:0] cnt_t;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    itype_e     w_type;
    a3_sel_e    w_a3_sel;
    logic [4:0] w_a3;
    logic       w_rs_use;
    logic       w_rt_use;
    logic       w_ri;
    entry_t     w_entry;
    entry_t     w_head;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    cnt_t             r_count;

    assign w_op    = in_ir[31:26];
    assign w_rs    = in_ir[25:21];
    assign w_funct = in_ir[5:0];

    // Decode the incoming word into a class, a destination source and operand-use flags.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_type   = T_NOP;
        w_a3_sel = A3_ZERO;
        w_rs_use = 1'b0;
        w_rt_use = 1'b0;
        w_ri     = 1'b0;
        case (w_op)
            6'b000000: begin
                if (in_ir != 32'h0000_0000) begin
                    case (w_funct)
                        6'b100000: begin w_type = T_ADD;   w_a3_sel = A3_RD; w_rs_use = 1'b1; w_rt_use = 1'b1; end
                        6'b100010: begin w_type = T_SUB;   w_a3_sel = A3_RD; w_rs_use = 1'b1; w_rt_use = 1'b1; end
                        6'b100100: begin w_type = T_AND;   w_a3_sel = A3_RD; w_rs_use = 1'b1; w_rt_use = 1'b1; end
                        6'b100101: begin w_type = T_OR;    w_a3_sel = A3_RD; w_rs_use = 1'b1; w_rt_use = 1'b1; end
                        6'b101010: begin w_type = T_SLT;   w_a3_sel = A3_RD; w_rs_use = 1'b1; w_rt_use = 1'b1; end
                        6'b101011: begin w_type = T_SLTU;  w_a3_sel = A3_RD; w_rs_use = 1'b1; w_rt_use = 1'b1; end
                        6'b011000: begin w_type = T_MULT;  w_rs_use = 1'b1; w_rt_use = 1'b1; end
                        6'b011001: begin w_type = T_MULTU; w_rs_use = 1'b1; w_rt_use = 1'b1; end
                        6'b011010: begin w_type = T_DIV;   w_rs_use = 1'b1; w_rt_use = 1'b1; end
                        6'b011011: begin w_type = T_DIVU;  w_rs_use = 1'b1; w_rt_use = 1'b1; end
                        6'b010000: begin w_type = T_MFHI;  w_a3_sel = A3_RD; end
                        6'b010010: begin w_type = T_MFLO;  w_a3_sel = A3_RD; end
                        6'b010001: begin w_type = T_MTHI;  w_rs_use = 1'b1; end
                        6'b010011: begin w_type = T_MTLO;  w_rs_use = 1'b1; end
                        6'b001000: begin w_type = T_JR;    w_rs_use = 1'b1; end
                        6'b001100: begin w_type = T_SYSCALL; end
                        default:   begin w_ri = 1'b1; end
                    endcase
                end
            end
            6'b001111: begin w_type = T_LUI;  w_a3_sel = A3_RT; end
            6'b001000: begin w_type = T_ADDI; w_a3_sel = A3_RT; w_rs_use = 1'b1; end
            6'b001100: begin w_type = T_ANDI; w_a3_sel = A3_RT; w_rs_use = 1'b1; end
            6'b001101: begin w_type = T_ORI;  w_a3_sel = A3_RT; w_rs_use = 1'b1; end
            6'b100000: begin w_type = T_LB;   w_a3_sel = A3_RT; w_rs_use = 1'b1; end
            6'b100001: begin w_type = T_LH;   w_a3_sel = A3_RT; w_rs_use = 1'b1; end
            6'b100011: begin w_type = T_LW;   w_a3_sel = A3_RT; w_rs_use = 1'b1; end
            6'b101000: begin w_type = T_SB;   w_rs_use = 1'b1; w_rt_use = 1'b1; end
            6'b101001: begin w_type = T_SH;   w_rs_use = 1'b1; w_rt_use = 1'b1; end
            6'b101011: begin w_type = T_SW;   w_rs_use = 1'b1; w_rt_use = 1'b1; end
            6'b000100: begin w_type = T_BEQ;  w_rs_use = 1'b1; w_rt_use = 1'b1; end
            6'b000101: begin w_type = T_BNE;  w_rs_use = 1'b1; w_rt_use = 1'b1; end
            6'b000011: begin w_type = T_JAL;  w_a3_sel = A3_RA; end
            6'b010000: begin
                if (w_rs == 5'b00000) begin
                    w_type   = T_MFC0;
                    w_a3_sel = A3_RT;
                end else if (w_rs == 5'b00100) begin
                    w_type   = T_MTC0;
                    w_rt_use = 1'b1;
                end else if (w_funct == 6'b011000) begin
                    w_type   = T_ERET;
                end else begin
                    w_ri     = 1'b1;
                end
            end
            default: begin w_ri = 1'b1; end
        endcase
    end

    // Pick the destination register number from the selected field.
    always_comb begin
        w_a3 = 5'd0;
        case (w_a3_sel)
            A3_RT:   w_a3 = in_ir[20:16];
            A3_RD:   w_a3 = in_ir[15:11];
            A3_RA:   w_a3 = 5'd31;
            default: w_a3 = 5'd0;
        endcase
    end

    assign w_entry = '{ir: in_ir, pc: in_pc, itype: w_type, a1: in_ir[25:21], a2: in_ir[20:16],
                       a3: w_a3, rs_use: w_rs_use, rt_use: w_rt_use, ri: w_ri};

    assign w_full   = (r_count == cnt_t'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    assign out_valid = !w_empty;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    // Pointer and occupancy bookkeeping. A flush clears everything and overrides push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + cnt_t'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - cnt_t'(1);
        end
    end

    // Store the decoded entry in the slot at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; its contents are meaningless while count marks the slots as empty.
        if (w_push)
            r_mem[r_wr_ptr] <= w_entry;
    end

    // Present the head entry, or all zeros when there is nothing to present.
    always_comb begin
        w_head = '0;
        if (!w_empty)
            w_head = r_mem[r_rd_ptr];
    end

    assign out_ir     = w_head.ir;
    assign out_pc     = w_head.pc;
    assign out_type   = w_head.itype;
    assign out_a1     = w_head.a1;
    assign out_a2     = w_head.a2;
    assign out_a3     = w_head.a3;
    assign out_rs_use = w_head.rs_use;
    assign out_rt_use = w_head.rt_use;
    assign out_ri     = w_head.ri;
    assign count      = r_count;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: self-checking bench for decode_queue with a queue-based reference model.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [5:0]  typ;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic        rs_use;
        logic        rt_use;
        logic        ri;
    } exp_t;

    localparam logic [5:0] R_FN [16] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd43, 6'd24, 6'd25,
                                         6'd26, 6'd27, 6'd16, 6'd18, 6'd17, 6'd19, 6'd8, 6'd12};
    localparam logic [5:0] I_OP [13] = '{6'd15, 6'd8, 6'd12, 6'd13, 6'd32, 6'd33, 6'd35, 6'd40,
                                         6'd41, 6'd43, 6'd4, 6'd5, 6'd3};

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_ir;
    logic [31:0]      in_pc;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_ir;
    logic [31:0]      out_pc;
    logic [5:0]       out_type;
    logic [4:0]       out_a1;
    logic [4:0]       out_a2;
    logic [4:0]       out_a3;
    logic             out_rs_use;
    logic             out_rt_use;
    logic             out_ri;
    logic [PTR_W:0]   count;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ir(in_ir), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ir(out_ir), .out_pc(out_pc), .out_type(out_type),
        .out_a1(out_a1), .out_a2(out_a2), .out_a3(out_a3),
        .out_rs_use(out_rs_use), .out_rt_use(out_rt_use), .out_ri(out_ri),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: classify the word, then derive the other fields from class membership.
    function automatic exp_t ref_decode(input logic [31:0] ir, input logic [31:0] pc);
        exp_t e;
        int   t;
        logic [5:0] op;
        logic [5:0] fn;
        op = ir[31:26];
        fn = ir[5:0];
        t  = 0;
        e  = '0;
        if (ir == 32'h0) begin
            t = 0;
        end else if (op == 6'd0) begin
            case (fn)
                6'd32: t = 1;   6'd34: t = 2;   6'd36: t = 3;   6'd37: t = 4;
                6'd42: t = 5;   6'd43: t = 6;   6'd24: t = 17;  6'd25: t = 18;
                6'd26: t = 19;  6'd27: t = 20;  6'd16: t = 21;  6'd18: t = 22;
                6'd17: t = 23;  6'd19: t = 24;  6'd8:  t = 28;  6'd12: t = 32;
                default: e.ri = 1'b1;
            endcase
        end else if (op == 6'd16) begin
            if (ir[25:21] == 5'd0)      t = 29;
            else if (ir[25:21] == 5'd4) t = 30;
            else if (fn == 6'd24)       t = 31;
            else                        e.ri = 1'b1;
        end else begin
            case (op)
                6'd15: t = 7;   6'd8:  t = 8;   6'd12: t = 9;   6'd13: t = 10;
                6'd32: t = 11;  6'd33: t = 12;  6'd35: t = 13;  6'd40: t = 14;
                6'd41: t = 15;  6'd43: t = 16;  6'd4:  t = 25;  6'd5:  t = 26;
                6'd3:  t = 27;
                default: e.ri = 1'b1;
            endcase
        end
        e.ir  = ir;
        e.pc  = pc;
        e.typ = 6'(t);
        e.a1  = ir[25:21];
        e.a2  = ir[20:16];
        if (e.ri)                             e.a3 = 5'd0;
        else if (t inside {[1:6], 21, 22})    e.a3 = ir[15:11];
        else if (t inside {[7:13], 29})       e.a3 = ir[20:16];
        else if (t == 27)                     e.a3 = 5'd31;
        else                                  e.a3 = 5'd0;
        e.rs_use = !e.ri && (t inside {[1:6], [8:20], 23, 24, 25, 26, 28});
        e.rt_use = !e.ri && (t inside {[1:6], [14:20], 25, 26, 30});
        return e;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: begin w[31:26] = 6'd0; w[5:0] = R_FN[$urandom_range(0, 15)]; end
            4, 5, 6, 7: begin w[31:26] = I_OP[$urandom_range(0, 12)]; end
            8: begin
                w[31:26] = 6'd16;
                case ($urandom_range(0, 3))
                    0: w[25:21] = 5'd0;
                    1: w[25:21] = 5'd4;
                    2: w[25:21] = 5'd16;
                    default: ;
                endcase
                if ($urandom_range(0, 1) == 1) w[5:0] = 6'd24;
            end
            default: if ($urandom_range(0, 1) == 1) w = 32'h0;
        endcase
        return w;
    endfunction

    // Monitor: compare the DUT against the model head, then advance the model for the coming edge.
    always @(negedge clk) begin : monitor
        exp_t a;
        exp_t e;
        logic pop;
        logic push;
        if (reset) exp_q.delete();
        a = {out_ir, out_pc, out_type, out_a1, out_a2, out_a3, out_rs_use, out_rt_use, out_ri};
        e = '0;
        if (exp_q.size() != 0) e = exp_q[0];
        check("count", 88'(count), 88'(exp_q.size()));
        check("out_valid", 88'(out_valid), 88'(exp_q.size() != 0));
        check("in_ready", 88'(in_ready), 88'(exp_q.size() < DEPTH));
        check("head", a, e);
        if (!reset) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                pop  = (exp_q.size() != 0) && out_ready;
                push = in_valid && (exp_q.size() < DEPTH);
                if (pop)  void'(exp_q.pop_front());
                if (push) exp_q.push_back(ref_decode(in_ir, in_pc));
            end
        end
    end

    // Drive one cycle of inputs, then return just after the following rising edge.
    task automatic cycle(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_ir     = ir;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc = '0; out_ready = 1'b0;
        #2;
        check("rst_count", 88'(count), 88'(0));
        check("rst_out_valid", 88'(out_valid), 88'(0));
        check("rst_in_ready", 88'(in_ready), 88'(1));
        check("rst_out_ir", 88'(out_ir), 88'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // add $2,$4,$5 into an empty queue
        cycle(1'b1, 32'h0085_1020, 32'h3000, 1'b0, 1'b0);
        check("add_type", 88'(out_type), 88'(1));
        check("add_a1a2a3", 88'({out_a1, out_a2, out_a3}), 88'({5'd4, 5'd5, 5'd2}));
        check("add_flags", 88'({out_rs_use, out_rt_use, out_ri}), 88'(3'b110));
        check("add_count", 88'(count), 88'(1));

        // pop the add while pushing lw, then fill with jal, mfc0 and an undefined word
        cycle(1'b1, 32'h8C82_0004, 32'h3004, 1'b1, 1'b0);
        cycle(1'b1, 32'h0C00_0C00, 32'h3008, 1'b0, 1'b0);
        cycle(1'b1, 32'h4002_6000, 32'h300C, 1'b0, 1'b0);
        cycle(1'b1, 32'hFC00_0000, 32'h3010, 1'b0, 1'b0);
        check("fill_count", 88'(count), 88'(4));
        check("fill_in_ready", 88'(in_ready), 88'(0));
        check("lw_fields", 88'({out_type, out_a3, out_rt_use}), 88'({6'd13, 5'd2, 1'b0}));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("jal_fields", 88'({out_type, out_a3}), 88'({6'd27, 5'd31}));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("mfc0_fields", 88'({out_type, out_a3}), 88'({6'd29, 5'd2}));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("undef_fields", 88'({out_type, out_ri, out_a3}), 88'({6'd0, 1'b1, 5'd0}));
        check("undef_pc", 88'(out_pc), 88'(32'h3010));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drain1_valid", 88'(out_valid), 88'(0));

        // five pushes into a four-entry queue, then drain
        for (int i = 0; i < 5; i++)
            cycle(1'b1, rand_ir(), 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
        check("full_count", 88'(count), 88'(4));
        check("full_in_ready", 88'(in_ready), 88'(0));
        for (int i = 0; i < 4; i++) begin
            check("full_pc_order", 88'(out_pc), 88'(32'h4000 + 32'(4 * i)));
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        check("empty_valid", 88'(out_valid), 88'(0));
        check("empty_outs", 88'({out_ir, out_pc, out_type}), 88'(0));

        // steady push+pop at count=2 so the pointers wrap several times
        cycle(1'b1, rand_ir(), 32'h5000, 1'b0, 1'b0);
        cycle(1'b1, rand_ir(), 32'h5004, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, rand_ir(), 32'h5008 + 32'(4 * i), 1'b1, 1'b0);
        check("stream_count", 88'(count), 88'(2));

        // flush with a simultaneous push at count=3
        cycle(1'b1, rand_ir(), 32'h6000, 1'b0, 1'b0);
        check("preflush_count", 88'(count), 88'(3));
        cycle(1'b1, 32'h0085_1020, 32'h6004, 1'b1, 1'b1);
        check("flush_count", 88'(count), 88'(0));
        check("flush_valid", 88'(out_valid), 88'(0));
        check("flush_in_ready", 88'(in_ready), 88'(1));
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("flush_no_word", 88'(out_valid), 88'(0));

        // asynchronous reset between edges with count=2
        cycle(1'b1, rand_ir(), 32'h7000, 1'b0, 1'b0);
        cycle(1'b1, rand_ir(), 32'h7004, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("arst_count", 88'(count), 88'(0));
        check("arst_valid", 88'(out_valid), 88'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b1, 32'h0085_1020, 32'h7100, 1'b0, 1'b0);
        check("post_rst_pc", 88'(out_pc), 88'(32'h7100));

        // randomized traffic
        for (int i = 0; i < 2000; i++)
            cycle($urandom_range(0, 9) < 7, rand_ir(), $urandom, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 2);
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decoded-instruction buffer between the F and D pipeline stages. Accepts raw 32-bit MIPS instruction words with their PC through a valid/ready handshake and decodes each word at enqueue into an instruction class, register addresses A1/A2/A3, operand-use flags and a reserved-instruction flag. Stores the result in a DEPTH-entry circular FIFO and presents the oldest entry to D. Decoupling fetch from decode stalls and supporting a pipeline flush is behaviour the combinational decoder does not provide.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer width. Derived; do not override.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; discards all entries.
- in_valid  in  1  F offers an instruction.
- in_ir  in  32  instruction word.
- in_pc  in  32  instruction PC.
- in_ready  out  1  queue can accept; equals !full.
- out_valid  out  1  head entry is valid; equals !empty.
- out_ready  in  1  D consumes the head this cycle.
- out_ir  out  32  head instruction word.
- out_pc  out  32  head PC.
- out_type  out  6  instruction class code (see Operation).
- out_a1, out_a2, out_a3  out  5 each  rs, rt and destination register.
- out_rs_use, out_rt_use  out  1 each  instruction reads rs / rt.
- out_ri  out  1  reserved (undecodable) instruction.
- count  out  PTR_W+1  occupied entries, 0..DEPTH.

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both may occur in the same cycle.
- Class codes (shared numbering in head.v):
  - NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, LUI 7, ADDI 8, ANDI 9, ORI 10
  - LB 11, LH 12, LW 13, SB 14, SH 15, SW 16
  - MULT 17, MULTU 18, DIV 19, DIVU 20, MFHI 21, MFLO 22, MTHI 23, MTLO 24
  - BEQ 25, BNE 26, JAL 27, JR 28, MFC0 29, MTC0 30, ERET 31, SYSCALL 32
- Opcodes and funct values are standard MIPS.
  - MFC0: op 010000 with rs 00000. MTC0: op 010000 with rs 00100. ERET: op 010000 with funct 011000.
  - Word 0x00000000 is NOP with ri=0.
- Any other word decodes as type NOP with ri=1. Its A3 is forced to 0.
- A1 = ir[25:21]. A2 = ir[20:16].
- A3 rules:
  - 0 for SW/SH/SB/BEQ/BNE/JR/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MTC0/ERET/SYSCALL/NOP.
  - 31 for JAL.
  - ir[20:16] for LW/LH/LB/LUI/ADDI/ANDI/ORI/MFC0.
  - ir[15:11] otherwise.
- rs_use = 1 for:
  - ALU R-type, ADDI/ANDI/ORI, all loads and stores
  - MULT/MULTU/DIV/DIVU, MTHI/MTLO, BEQ/BNE, JR
- rt_use = 1 for: ALU R-type, stores, MULT/MULTU/DIV/DIVU, BEQ/BNE, MTC0.
- Decode is computed combinationally from in_ir. All decoded fields plus ir and pc are written into the slot at wr_ptr on push.
- Pointers: wr_ptr and rd_ptr are PTR_W bits and wrap modulo DEPTH. count increments on push only, decrements on pop only, and is unchanged on push+pop.
- Out ports are driven from the rd_ptr slot when out_valid=1, and forced to all-zero when empty.
- flush: count, wr_ptr and rd_ptr are cleared at the next edge. Flush overrides a same-cycle push and pop; the pushed word is lost.

## Timing
- Reset (asynchronous): count=0, pointers=0, out_valid=0, in_ready=1, all out_* = 0. Storage contents are don't-care.
- Enqueue latency: a word pushed at edge N is visible on out_* after edge N when the queue was empty. There is no combinational in→out path.
- in_ready depends only on count. out_ready never affects in_ready in the same cycle.
- Full (count=DEPTH): in_ready=0. A pop frees one slot, and in_ready=1 after that edge.
- Empty with push only: out_valid=1 after the edge. A pop while empty is ignored.
- Push+pop with 0<count<DEPTH: count holds and both pointers advance.
- Reset asserted mid-stream discards all entries immediately. The first push after deassertion lands in slot 0.

## Test plan
- Reset, then push 0x00851020 (add $2,$4,$5), pc 0x3000, with out_ready=0 → next cycle out_valid=1, type=1, a1=4, a2=5, a3=2, rs_use=1, rt_use=1, ri=0, count=1.
- Push lw 0x8C820004, jal 0x0C000C00, mfc0 0x40026000, and an undefined word 0xFC000000 →
  - lw: type 13, a3=2, rt_use=0
  - jal: type 27, a3=31
  - mfc0: type 29, a3=2
  - undefined word: type 0, ri=1, a3=0
- DEPTH=4: push 5 words with out_ready=0 → in_ready=0 after the 4th push, count=4, 5th word not accepted. Pop all → words exit in order with correct PCs, then out_valid=0 and outputs zero.
- Hold in_valid=1 and out_ready=1 for 20 cycles with count=2 → count stays 2, pointers wrap, output order matches input order.
- With count=3, assert flush together with in_valid=1 → next cycle count=0, out_valid=0, in_ready=1, and the flushed word never appears.
- Assert reset asynchronously between edges with count=2 → out_valid and count drop to 0 before the next edge.
